// File: rtl/fir_l2_serializer.sv
// Serializes y(2k), y(2k+1) pairs from the L=2 parallel FIR into one sample per clock.
// A small pair FIFO absorbs bursts. The output stage emits the even sample, then the odd one.
module fir_l2_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_y0,
    input  logic [DATA_WIDTH-1:0]         in_y1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          out_odd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;

    logic [1:0]              state;
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0] head;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [DATA_WIDTH-1:0]   y1_hold;
    logic                    push;
    logic                    advance;
    logic                    pop;
    logic [CW-1:0]           count_nxt;

    // The output stage only pulls from the registered count, so a pair pushed
    // at this edge cannot be popped until the next one.
    assign push      = in_valid && in_ready;
    assign advance   = (state == S_IDLE) || ((state == S_ODD) && out_ready);
    assign pop       = advance && (fifo_count != '0);
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_y1, in_y0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= count_nxt;
            in_ready   <= (count_nxt < DEPTH_C);
        end
    end

    // A pop loads y0 straight to the output and parks y1 for the next beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_odd   <= 1'b0;
            data_out  <= '0;
            y1_hold   <= '0;
        end else if (pop) begin
            state     <= S_EVEN;
            out_valid <= 1'b1;
            out_odd   <= 1'b0;
            data_out  <= head[DATA_WIDTH-1:0];
            y1_hold   <= head[2*DATA_WIDTH-1:DATA_WIDTH];
        end else if ((state == S_EVEN) && out_ready) begin
            state    <= S_ODD;
            out_odd  <= 1'b1;
            data_out <= y1_hold;
        end else if ((state == S_ODD) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_odd   <= 1'b0;
        end else if ((state != S_IDLE) && (state != S_EVEN) && (state != S_ODD)) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_odd   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_l2_serializer.sv
// Directed bench for fir_l2_serializer: latency, streaming, full FIFO, stalls and mid-pair reset.
module tb_fir_l2_serializer;
    localparam int DW = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_y0;
    logic [DW-1:0] in_y1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out;
    logic          out_odd;
    logic [2:0]    fifo_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] expq[$];

    fir_l2_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_y0(in_y0), .in_y1(in_y1),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_odd(out_odd), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Consume n samples at full rate against expq, then confirm the block is empty.
    task automatic drain(input int n);
        int got;
        got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 * n + 10 && got < n; cyc++) begin
            if (out_valid) begin
                chk("drain_d", data_out, expq.pop_front());
                chk("drain_odd", out_odd, 64'(got % 2));
                got++;
            end
            tick;
        end
        chk("drain_n", 64'(got), 64'(n));
        chk("drain_idle", out_valid, 0);
        chk("drain_cnt", fifo_count, 0);
    endtask

    initial begin
        int p;
        int pidx;
        int oidx;
        int stale;
        logic pushed, took, held, po;
        logic [DW-1:0] pd;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_y0 = '0; in_y1 = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_data", data_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rel_ready", in_ready, 0);
        tick;
        chk("rdy_rise", in_ready, 1);

        // single pair latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_y0 = 64'd5; in_y1 = -64'sd3;
        tick;
        in_valid = 1'b0;
        chk("sp_cnt", fifo_count, 1);
        chk("sp_nv", out_valid, 0);
        tick;
        chk("sp_v0", out_valid, 1);
        chk("sp_d0", data_out, 64'd5);
        chk("sp_o0", out_odd, 0);
        tick;
        chk("sp_d1", data_out, -64'sd3);
        chk("sp_o1", out_odd, 1);
        tick;
        chk("sp_idle", out_valid, 0);

        // streaming, one pair every other edge
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2 == 0) && (c < 8);
            in_y0 = 64'(c + 1);
            in_y1 = 64'(c + 2);
            tick;
            if (c >= 1 && c <= 8) begin
                chk("strm_d", data_out, 64'(c));
                chk("strm_v", out_valid, 1);
            end
            if (c == 9) chk("strm_idle", out_valid, 0);
            chk("strm_cnt", fifo_count <= 3'd1, 1);
        end
        in_valid = 1'b0;

        // backpressure until full
        out_ready = 1'b0;
        in_valid = 1'b1;
        p = 0;
        for (int c = 0; c < 8; c++) begin
            in_y0 = 64'(100 + 2 * p);
            in_y1 = 64'(101 + 2 * p);
            pushed = in_ready;
            if (pushed) begin
                expq.push_back(in_y0);
                expq.push_back(in_y1);
            end
            tick;
            if (pushed) p++;
        end
        in_valid = 1'b0;
        chk("full_pairs", 64'(p), 5);
        chk("full_cnt", fifo_count, 4);
        chk("full_rdy", in_ready, 0);
        chk("full_head", data_out, 64'd100);
        drain(10);
        chk("full_rdy_back", in_ready, 1);

        // push and pop on the same edge with count = DEPTH-1
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_y0 = 64'(300 + 2 * c);
            in_y1 = 64'(301 + 2 * c);
            if (c > 0) begin
                expq.push_back(in_y0);
                expq.push_back(in_y1);
            end
            tick;
        end
        in_valid = 1'b0;
        chk("pp_cnt3", fifo_count, 3);
        chk("pp_even", data_out, 64'd300);
        out_ready = 1'b1;
        tick;
        chk("pp_odd", data_out, 64'd301);
        in_valid = 1'b1; in_y0 = 64'd308; in_y1 = 64'd309;
        expq.push_back(in_y0);
        expq.push_back(in_y1);
        tick;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_cnt", fifo_count, 3);
        chk("pp_rdy", in_ready, 1);
        chk("pp_next", data_out, 64'd302);
        chk("pp_nodd", out_odd, 0);
        drain(8);

        // random stalls
        for (int k = 0; k < 6; k++) begin
            expq.push_back(64'(200 + 2 * k));
            expq.push_back(64'(201 + 2 * k));
        end
        pidx = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 300 && oidx < 12; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (pidx < 6);
            in_y0 = 64'(200 + 2 * pidx);
            in_y1 = 64'(201 + 2 * pidx);
            pushed = in_valid && in_ready;
            took = out_valid && out_ready;
            held = out_valid && !out_ready;
            pd = data_out;
            po = out_odd;
            if (took) begin
                chk("stall_d", data_out, expq.pop_front());
                chk("stall_odd", out_odd, 64'(oidx % 2));
                oidx++;
            end
            tick;
            if (pushed) pidx++;
            if (held) begin
                chk("hold_d", data_out, pd);
                chk("hold_o", out_odd, po);
                chk("hold_v", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        chk("stall_n", 64'(oidx), 12);

        // reset while in ODD with two pairs queued
        out_ready = 1'b0;
        tick;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_y0 = 64'(400 + 2 * c);
            in_y1 = 64'(401 + 2 * c);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("mr_odd", out_odd, 1);
        chk("mr_d", data_out, 64'd401);
        chk("mr_cnt", fifo_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", data_out, 0);
        chk("mr_cnt0", fifo_count, 0);
        chk("mr_rdy", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (out_valid) stale++;
        end
        chk("mr_stale", 64'(stale), 0);
        chk("mr_cnt_after", fifo_count, 0);
        in_valid = 1'b1; in_y0 = 64'd9; in_y1 = -64'sd10;
        expq.push_back(in_y0);
        expq.push_back(in_y1);
        tick;
        in_valid = 1'b0;
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
